// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU scheduler:
// ALU select codes, scheduler states and default widths.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int OPW_DEF   = 3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester
// that did not win last time gets the grant.
module rr_arb2 (
    input  logic v0,
    input  logic v1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = v0 | v1;
    assign grant_id    = v1 & (~v0 | ~last_grant);

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: arbitrate, issue,
// wait the fixed ALU latency, return a tagged response.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
        $error("alu_share_ctrl: ALU_LAT must be 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic             last_grant, last_n;
    logic             gv, gid;
    logic [WIDTH-1:0] alu_a_n, alu_b_n, res_n;
    logic [OPW-1:0]   sel_n;
    logic             rv_n, id_n, zero_n;

    rr_arb2 u_arb (
        .v0          (r0_valid),
        .v1          (r1_valid),
        .last_grant  (last_grant),
        .grant_valid (gv),
        .grant_id    (gid)
    );

    assign r0_ready = (state == IDLE) & gv & ~gid;
    assign r1_ready = (state == IDLE) & gv & gid;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last_grant;
        alu_a_n = alu_a;
        alu_b_n = alu_b;
        sel_n   = alu_sel;
        rv_n    = rsp_valid;
        id_n    = rsp_id;
        res_n   = rsp_result;
        zero_n  = rsp_zero;
        unique case (state)
            IDLE: begin
                if (gv) begin
                    alu_a_n = gid ? r1_a : r0_a;
                    alu_b_n = gid ? r1_b : r0_b;
                    sel_n   = gid ? r1_op : r0_op;
                    id_n    = gid;
                    last_n  = gid;
                    cnt_n   = LAT_M1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    res_n   = alu_result;
                    zero_n  = (alu_result == '0);
                    rv_n    = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                // no accept on the handshake edge; IDLE re-arbitrates
                if (rsp_ready) begin
                    rv_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_grant <= last_n;
            alu_a      <= alu_a_n;
            alu_b      <= alu_b_n;
            alu_sel    <= sel_n;
            rsp_valid  <= rv_n;
            rsp_id     <= id_n;
            rsp_result <= res_n;
            rsp_zero   <= zero_n;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: three latencies driven in parallel,
// checked every cycle against a timestamp-based reference model.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, rsp_ready;
    logic [2:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;

    logic        r0_ready [3];
    logic        r1_ready [3];
    logic [31:0] alu_a [3];
    logic [31:0] alu_b [3];
    logic [2:0]  alu_sel [3];
    logic [31:0] alu_result [3];
    logic        rsp_valid [3];
    logic        rsp_id [3];
    logic [31:0] rsp_result [3];
    logic        rsp_zero [3];
    logic        busy [3];

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(
        logic [31:0] a, logic [31:0] b, logic [2:0] s);
        case (s)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a ^ b;
            3'b101:  return ~(a | b);
            3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a;
        endcase
    endfunction

    function automatic int lat_of(int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    assign alu_result[0] = alu_f(alu_a[0], alu_b[0], alu_sel[0]);
    assign alu_result[1] = alu_f(alu_a[1], alu_b[1], alu_sel[1]);
    assign alu_result[2] = alu_f(alu_a[2], alu_b[2], alu_sel[2]);

    alu_share_ctrl #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) u0 (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready[0]), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready[0]), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
        .alu_result(alu_result[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id[0]), .rsp_result(rsp_result[0]),
        .rsp_zero(rsp_zero[0]), .busy(busy[0]));

    alu_share_ctrl #(.WIDTH(32), .OPW(3), .ALU_LAT(4)) u1 (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready[1]), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready[1]), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
        .alu_result(alu_result[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id[1]), .rsp_result(rsp_result[1]),
        .rsp_zero(rsp_zero[1]), .busy(busy[1]));

    alu_share_ctrl #(.WIDTH(32), .OPW(3), .ALU_LAT(8)) u2 (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready[2]), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready[2]), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b),
        .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_sel(alu_sel[2]),
        .alu_result(alu_result[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id[2]), .rsp_result(rsp_result[2]),
        .rsp_zero(rsp_zero[2]), .busy(busy[2]));

    // Reference model: an op accepted at edge E responds at edge E+LAT
    // and is retired by the first rsp_ready edge after that.
    bit          m_infl [3];
    bit          m_rv [3];
    int          m_due [3];
    bit          m_last [3];
    logic [31:0] m_a [3];
    logic [31:0] m_b [3];
    logic [2:0]  m_sel [3];
    bit          m_id [3];
    logic [31:0] m_res [3];
    bit          m_zero [3];
    int          edges = 0;

    bit hs0_log [$];
    int rv2_cnt = 0;
    int id0_hs  = 0;

    task automatic mreset(int i);
        m_infl[i] = 0;
        m_rv[i]   = 0;
        m_due[i]  = 0;
        m_last[i] = 1;
        m_a[i]    = '0;
        m_b[i]    = '0;
        m_sel[i]  = '0;
        m_id[i]   = 0;
        m_res[i]  = '0;
        m_zero[i] = 0;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        edges++;
        for (int i = 0; i < 3; i++) begin
            if (!reset && rsp_valid[i] && rsp_ready) begin
                if (i == 0) hs0_log.push_back(rsp_id[0]);
                if (!rsp_id[i]) id0_hs++;
            end
            if (!reset && i == 2 && rsp_valid[2]) rv2_cnt++;
            if (reset) begin
                mreset(i);
            end else if (!m_infl[i]) begin
                if (r0_valid || r1_valid) begin
                    bit w;
                    w = (r0_valid && r1_valid) ? !m_last[i] : r1_valid;
                    m_a[i]    = w ? r1_a : r0_a;
                    m_b[i]    = w ? r1_b : r0_b;
                    m_sel[i]  = w ? r1_op : r0_op;
                    m_id[i]   = w;
                    m_last[i] = w;
                    m_infl[i] = 1;
                    m_due[i]  = edges + lat_of(i);
                end
            end else if (!m_rv[i]) begin
                if (edges == m_due[i]) begin
                    m_res[i]  = alu_f(m_a[i], m_b[i], m_sel[i]);
                    m_zero[i] = (m_res[i] == 0);
                    m_rv[i]   = 1;
                end
            end else if (rsp_ready) begin
                m_rv[i]   = 0;
                m_infl[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit any, w, e0, e1;
            if (reset) mreset(i);
            any = r0_valid || r1_valid;
            w   = (r0_valid && r1_valid) ? !m_last[i] : r1_valid;
            e0  = !m_infl[i] && any && !w;
            e1  = !m_infl[i] && any && w;
            chk($sformatf("u%0d.r0_ready", i), 32'(r0_ready[i]), 32'(e0));
            chk($sformatf("u%0d.r1_ready", i), 32'(r1_ready[i]), 32'(e1));
            chk($sformatf("u%0d.alu_a", i), alu_a[i], m_a[i]);
            chk($sformatf("u%0d.alu_b", i), alu_b[i], m_b[i]);
            chk($sformatf("u%0d.alu_sel", i), 32'(alu_sel[i]), 32'(m_sel[i]));
            chk($sformatf("u%0d.rsp_valid", i), 32'(rsp_valid[i]), 32'(m_rv[i]));
            chk($sformatf("u%0d.rsp_id", i), 32'(rsp_id[i]), 32'(m_id[i]));
            chk($sformatf("u%0d.rsp_result", i), rsp_result[i], m_res[i]);
            chk($sformatf("u%0d.rsp_zero", i), 32'(rsp_zero[i]), 32'(m_zero[i]));
            chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_infl[i]));
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            if (!busy[0] && !busy[1] && !busy[2]) return;
            step(1);
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rv(int i, output int n);
        n = 0;
        while (!rsp_valid[i] && n < 20) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        r0_valid = 0; r1_valid = 0; rsp_ready = 1;
        r0_op = '0; r1_op = '0;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        step(2);
        chk("reset.busy", 32'(busy[2]), 32'd0);
        chk("reset.alu_a", alu_a[0], 32'd0);
        reset = 1'b0;

        // single OR op from r0
        r0_valid = 1; r0_op = 3'b001;
        r0_a = 32'h0F0F0000; r0_b = 32'h000000FF;
        #1;
        chk("t1.r0_ready", 32'(r0_ready[0]), 32'd1);
        chk("t1.r1_ready", 32'(r1_ready[0]), 32'd0);
        step(1);
        r0_valid = 0;
        chk("t1.alu_sel", 32'(alu_sel[0]), 32'd1);
        chk("t1.r0_ready_off", 32'(r0_ready[0]), 32'd0);
        step(1);
        chk("t1.rsp_valid", 32'(rsp_valid[0]), 32'd1);
        chk("t1.rsp_result", rsp_result[0], 32'h0F0F00FF);
        chk("t1.rsp_id", 32'(rsp_id[0]), 32'd0);
        chk("t1.rsp_zero", 32'(rsp_zero[0]), 32'd0);
        wait_idle();

        // continuous contention alternates grants
        reset = 1; step(1); reset = 0;
        hs0_log.delete();
        r0_valid = 1; r0_op = 3'b010; r0_a = 32'd1; r0_b = 32'd2;
        r1_valid = 1; r1_op = 3'b100; r1_a = 32'hF0; r1_b = 32'hFF;
        step(40);
        r0_valid = 0; r1_valid = 0;
        chk("t2.hs_count", 32'(hs0_log.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < hs0_log.size(); k++)
            chk($sformatf("t2.grant%0d", k), 32'(hs0_log[k]), 32'(k % 2));
        wait_idle();

        // LAT=4 SUB with zero result, then held response
        rsp_ready = 0;
        r1_valid = 1; r1_op = 3'b011; r1_a = 32'd5; r1_b = 32'd5;
        #1;
        chk("t3.r1_ready", 32'(r1_ready[1]), 32'd1);
        step(1);
        r1_valid = 0;
        wait_rv(1, n);
        chk("t3.lat_edges", 32'(n), 32'd4);
        chk("t3.rsp_result", rsp_result[1], 32'd0);
        chk("t3.rsp_zero", 32'(rsp_zero[1]), 32'd1);
        chk("t3.rsp_id", 32'(rsp_id[1]), 32'd1);
        r0_valid = 1; r0_op = 3'b010; r0_a = 32'd7; r0_b = 32'd8;
        r1_valid = 1;
        step(10);
        chk("t4.busy", 32'(busy[1]), 32'd1);
        chk("t4.rsp_held", 32'(rsp_valid[1]), 32'd1);
        rsp_ready = 1;
        step(1);
        chk("t4.idle", 32'(busy[1]), 32'd0);
        chk("t4.r0_ready", 32'(r0_ready[1]), 32'd1);
        step(1);
        chk("t4.reaccept", 32'(busy[1]), 32'd1);
        chk("t4.alu_a", alu_a[1], 32'd7);
        r0_valid = 0; r1_valid = 0;
        wait_idle();

        // reset in the middle of a LAT=8 execution
        r0_valid = 1; r0_op = 3'b000;
        r0_a = 32'hFFFF; r0_b = 32'h0F0F;
        step(1);
        r0_valid = 0;
        step(3);
        chk("t5.in_exec", 32'(busy[2]), 32'd1);
        reset = 1;
        #1;
        chk("t5.rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("t5.busy", 32'(busy[2]), 32'd0);
        chk("t5.alu_a", alu_a[2], 32'd0);
        chk("t5.alu_b", alu_b[2], 32'd0);
        chk("t5.alu_sel", 32'(alu_sel[2]), 32'd0);
        step(1);
        reset = 0;
        rv2_cnt = 0;
        step(12);
        chk("t5.no_rsp", 32'(rv2_cnt), 32'd0);
        r0_valid = 1; r1_valid = 1;
        #1;
        chk("t5.tie_r0", 32'(r0_ready[2]), 32'd1);
        chk("t5.tie_r1", 32'(r1_ready[2]), 32'd0);
        step(1);
        r0_valid = 0; r1_valid = 0;
        wait_idle();

        // r0 pulse while everything sits in RESP
        rsp_ready = 0;
        r1_valid = 1; r1_op = 3'b001; r1_a = 32'h10; r1_b = 32'h01;
        step(1);
        r1_valid = 0;
        wait_rv(2, n);
        chk("t6.rsp_seen", 32'(rsp_valid[2]), 32'd1);
        id0_hs = 0;
        r0_valid = 1;
        step(1);
        r0_valid = 0;
        step(3);
        rsp_ready = 1;
        step(20);
        chk("t6.no_r0_rsp", 32'(id0_hs), 32'd0);
        chk("t6.idle", 32'(busy[2]), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
